// File: rtl/tile_seq_pkg.sv
// Shared types and tile-count helpers for the matmul tile sequencer.
package tile_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        OUT,
        DONE
    } state_t;

    // Returns 0 for a bad split so a bad configuration is caught at elaboration.
    function automatic int tile_count(input int dim, input int block);
        if (block <= 0 || (dim % block) != 0) return 0;
        return dim / block;
    endfunction

    function automatic int calc_kb(input int inner_dimension, input int block_size);
        return tile_count(inner_dimension, block_size);
    endfunction

    function automatic int calc_rc(input int row_size_mat_a, input int block_size);
        return tile_count(row_size_mat_a, block_size);
    endfunction

    function automatic int calc_cc(input int col_size_mat_b, input int block_size);
        return tile_count(col_size_mat_b, block_size);
    endfunction

endpackage

// File: rtl/tile_idx_counter.sv
// Wrapping tile index counter: counts 0..COUNT-1, clear has priority over increment.
module tile_idx_counter #(
    parameter int W     = 16,
    parameter int COUNT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         max,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(COUNT - 1);

    assign max  = (value == LAST);
    assign wrap = inc && !clr && max;

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= max ? '0 : value + W'(1);
        end
    end

endmodule

// File: rtl/matmul_tile_sequencer.sv
// Walks the (r, c, k) tile loops of an A x B product and hands each finished tile downstream.
// Optional stall counter output enabled by defining TILE_SEQ_PERF_CNT_EN.
module matmul_tile_sequencer
    import tile_seq_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int CHUNK_SIZE      = 4,
    parameter int BLOCK_SIZE      = 2,
    parameter int INNER_DIMENSION = 8,
    parameter int ROW_SIZE_MAT_A  = 16,
    parameter int COL_SIZE_MAT_B  = 10,
    parameter int ADDR_WIDTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [ADDR_WIDTH-1:0]         addr_a,
    output logic [ADDR_WIDTH-1:0]         addr_b,
    output logic                          core_rst,
    output logic                          core_en,
    output logic                          reset_acc,
    input  logic                          systolic_finish,
    input  logic                          accumulator_done,
    input  logic [WIDTH*CHUNK_SIZE-1:0]   core_out,
    output logic [WIDTH*CHUNK_SIZE-1:0]   out_data,
    output logic                          out_valid,
    output logic [ADDR_WIDTH-1:0]         out_row,
    output logic [ADDR_WIDTH-1:0]         out_col,
    input  logic                          out_ready
`ifdef TILE_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                   stall_cycles
`endif
);

    localparam int KB = calc_kb(INNER_DIMENSION, BLOCK_SIZE);
    localparam int RC = calc_rc(ROW_SIZE_MAT_A, BLOCK_SIZE);
    localparam int CC = calc_cc(COL_SIZE_MAT_B, BLOCK_SIZE);
    localparam logic [ADDR_WIDTH-1:0] KB_A = ADDR_WIDTH'(KB);

    if (KB == 0) begin : g_bad_kb
        $error("INNER_DIMENSION must be a nonzero multiple of BLOCK_SIZE");
    end
    if (RC == 0) begin : g_bad_rc
        $error("ROW_SIZE_MAT_A must be a nonzero multiple of BLOCK_SIZE");
    end
    if (CC == 0) begin : g_bad_cc
        $error("COL_SIZE_MAT_B must be a nonzero multiple of BLOCK_SIZE");
    end

    state_t                state;
    logic [ADDR_WIDTH-1:0] k, r, c;
    logic                  k_max, r_max, c_max;
    logic                  k_wrap, r_wrap, c_wrap;
    logic                  launch, accept, k_step;
    logic                  unused_status;

    assign launch = (state == IDLE) && start;
    assign accept = (state == OUT) && out_ready;
    assign k_step = (state == RUN) && systolic_finish && !k_max;
    assign unused_status = k_wrap | r_max;

    tile_idx_counter #(.W(ADDR_WIDTH), .COUNT(KB)) u_k_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (launch || accept),
        .inc   (k_step),
        .value (k),
        .max   (k_max),
        .wrap  (k_wrap)
    );

    // c is the inner loop; r only advances when c wraps.
    tile_idx_counter #(.W(ADDR_WIDTH), .COUNT(CC)) u_c_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (launch),
        .inc   (accept),
        .value (c),
        .max   (c_max),
        .wrap  (c_wrap)
    );

    tile_idx_counter #(.W(ADDR_WIDTH), .COUNT(RC)) u_r_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (launch),
        .inc   (accept && c_wrap),
        .value (r),
        .max   (r_max),
        .wrap  (r_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr_a    <= '0;
            addr_b    <= '0;
            core_rst  <= 1'b0;
            core_en   <= 1'b0;
            reset_acc <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            // NOTE: single-cycle strobes default low here; states below only raise them.
            done      <= 1'b0;
            core_rst  <= 1'b0;
            reset_acc <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        addr_a    <= '0;
                        addr_b    <= '0;
                        core_rst  <= 1'b1;
                        reset_acc <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    core_en <= 1'b1;
                    state   <= RUN;
                end
                RUN: begin
                    if (systolic_finish) begin
                        core_en <= 1'b0;
                        if (!k_max) begin
                            addr_a   <= addr_a + ADDR_WIDTH'(1);
                            addr_b   <= addr_b + ADDR_WIDTH'(1);
                            core_rst <= 1'b1;
                            state    <= LOAD;
                        end else if (accumulator_done) begin
                            out_valid <= 1'b1;
                            out_data  <= core_out;
                            out_row   <= r;
                            out_col   <= c;
                            state     <= OUT;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (accumulator_done) begin
                        out_valid <= 1'b1;
                        out_data  <= core_out;
                        out_row   <= r;
                        out_col   <= c;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (r_wrap) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            core_rst  <= 1'b1;
                            reset_acc <= 1'b1;
                            state     <= LOAD;
                            if (c_max) begin
                                addr_a <= KB_A * (r + ADDR_WIDTH'(1));
                                addr_b <= '0;
                            end else begin
                                addr_a <= KB_A * r;
                                addr_b <= KB_A * (c + ADDR_WIDTH'(1));
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef TILE_SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || launch) begin
            stall_cycles <= '0;
        end else if ((state == OUT) && !out_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Directed bench for matmul_tile_sequencer with a small reactive core model.
module tb_matmul_tile_sequencer;

    localparam int KB = 4;
    localparam int RC = 8;
    localparam int CC = 5;

    logic        clk = 1'b0;
    logic        rst, start, systolic_finish, accumulator_done, out_ready;
    logic        busy, done, core_rst, core_en, reset_acc, out_valid;
    logic [15:0] addr_a, addr_b, out_row, out_col;
    logic [63:0] core_out, out_data;
`ifdef TILE_SEQ_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int total = 0;
    int bad   = 0;
    int tile_idx = 0;
    int beats = 0;
    bit coincident = 1'b0;

    matmul_tile_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .addr_a           (addr_a),
        .addr_b           (addr_b),
        .core_rst         (core_rst),
        .core_en          (core_en),
        .reset_acc        (reset_acc),
        .systolic_finish  (systolic_finish),
        .accumulator_done (accumulator_done),
        .core_out         (core_out),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_row          (out_row),
        .out_col          (out_col),
        .out_ready        (out_ready)
`ifdef TILE_SEQ_PERF_CNT_EN
        ,
        .stall_cycles     (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] tile_word(input int n);
        logic [15:0] t;
        t = 16'(n);
        return {t * 16'd3 + 16'd1, t ^ 16'h5a5a, 16'hc000 | t, t << 4};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic observe();
        if (out_valid && out_ready) begin
            check($sformatf("beat%0d_row", tile_idx), out_row, 64'(tile_idx / CC));
            check($sformatf("beat%0d_col", tile_idx), out_col, 64'(tile_idx % CC));
            check($sformatf("beat%0d_data", tile_idx), out_data, tile_word(tile_idx));
            tile_idx++;
            beats++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tile_idx = 0;
        beats = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Core model: finish 4 cycles after core_rst, accumulator done 2 cycles after finish
    // (or in the same cycle when coincident is set).
    initial begin
        int fin_cnt;
        int acc_cnt;
        fin_cnt = 0;
        acc_cnt = 0;
        systolic_finish = 1'b0;
        accumulator_done = 1'b0;
        core_out = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                fin_cnt = 0;
                acc_cnt = 0;
            end
            if (core_rst) fin_cnt = 4;
            else if (fin_cnt > 0) fin_cnt--;
            systolic_finish = (fin_cnt == 1);
            if (acc_cnt > 0) acc_cnt--;
            if (coincident) begin
                accumulator_done = systolic_finish;
                acc_cnt = 0;
            end else begin
                accumulator_done = (acc_cnt == 1);
                if (systolic_finish) acc_cnt = 3;
            end
            core_out = tile_word(tile_idx);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int loads, dones, post, n13;
        bit flag;
        logic [15:0] a13 [4];
        logic [15:0] b13 [4];
        logic        r13 [4];
        logic [63:0] hold_d;

        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;

        // Reset state
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_addr_a", addr_a, 0);
        check("rst_addr_b", addr_b, 0);
        check("rst_core_en", core_en, 0);
        check("rst_core_rst", core_rst, 0);
        check("rst_out_data", out_data, 0);

        // Full product with out_ready held high
        pulse_start();
        check("a_busy", busy, 1);
        check("a_first_core_rst", core_rst, 1);
        check("a_first_reset_acc", reset_acc, 1);
        loads = 0;
        dones = 0;
        post = 0;
        n13 = 0;
        for (int cyc = 0; cyc < 3000 && post < 5; cyc++) begin
            if (core_rst) begin
                loads++;
                if (tile_idx == 13 && n13 < 4) begin
                    a13[n13] = addr_a;
                    b13[n13] = addr_b;
                    r13[n13] = reset_acc;
                    n13++;
                end
            end
            observe();
            if (done) begin
                dones++;
                check("a_done_busy_low", busy, 0);
            end
            if (dones > 0) post++;
            @(negedge clk);
        end
        check("a_beats", beats, 40);
        check("a_loads", loads, 160);
        check("a_dones", dones, 1);
        check("a_idle_busy", busy, 0);
        check("a_t13_loads", n13, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("a_t13_addr_a%0d", i), a13[i], 64'(8 + i));
            check($sformatf("a_t13_addr_b%0d", i), b13[i], 64'(12 + i));
            check($sformatf("a_t13_reset_acc%0d", i), r13[i], (i == 0) ? 64'd1 : 64'd0);
        end

        // Back-pressure on tile (0,0)
        do_reset();
        out_ready = 1'b0;
        pulse_start();
        for (int cyc = 0; cyc < 200 && !out_valid; cyc++) @(negedge clk);
        check("b_valid", out_valid, 1);
        check("b_row", out_row, 0);
        check("b_col", out_col, 0);
        check("b_data", out_data, tile_word(0));
        hold_d = out_data;
        flag = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!out_valid || out_data !== hold_d || out_row !== 16'd0 || out_col !== 16'd0 || core_rst)
                flag = 1'b0;
            @(negedge clk);
        end
        check("b_held_stable", flag, 1);
        check("b_still_valid", out_valid, 1);
`ifdef TILE_SEQ_PERF_CNT_EN
        check("b_stall_cycles", stall_cycles, 5);
`endif
        out_ready = 1'b1;
        @(negedge clk);
        check("b_next_load", core_rst, 1);
        check("b_next_addr_a", addr_a, 0);
        check("b_next_addr_b", addr_b, 4);
        check("b_valid_dropped", out_valid, 0);
`ifdef TILE_SEQ_PERF_CNT_EN
        check("b_stall_kept", stall_cycles, 5);
`endif

        // Reset during RUN of tile (3,1)
        do_reset();
        out_ready = 1'b1;
        pulse_start();
        for (int cyc = 0; cyc < 2000 && !(tile_idx == 16 && core_en); cyc++) begin
            observe();
            @(negedge clk);
        end
        check("c_reached_t16", (tile_idx == 16) && core_en, 1);
        check("c_run_addr_a", addr_a, 12);
        check("c_run_addr_b", addr_b, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("c_busy", busy, 0);
        check("c_valid", out_valid, 0);
        check("c_addr_a", addr_a, 0);
        check("c_addr_b", addr_b, 0);
        check("c_core_en", core_en, 0);
        tile_idx = 0;
        beats = 0;
        pulse_start();
        check("c_restart_load", core_rst, 1);
        check("c_restart_addr_a", addr_a, 0);
        check("c_restart_addr_b", addr_b, 0);
        for (int cyc = 0; cyc < 100 && beats == 0; cyc++) begin
            observe();
            @(negedge clk);
        end
        check("c_restart_beat", beats, 1);

        // Coincident accumulator_done, start while busy, start in DONE
        do_reset();
        coincident = 1'b1;
        out_ready = 1'b1;
        pulse_start();
        for (int cyc = 0; cyc < 200 && !(core_en && addr_a == 16'd2); cyc++) @(negedge clk);
        check("d_run_k2", core_en && (addr_a == 16'd2), 1);
        pulse_start();
        check("d_busy_kept", busy, 1);
        for (int cyc = 0; cyc < 50 && !core_rst; cyc++) @(negedge clk);
        check("d_no_restart_a", addr_a, 3);
        check("d_no_restart_b", addr_b, 3);
        for (int cyc = 0; cyc < 50 && !systolic_finish; cyc++) @(negedge clk);
        check("d_final_fin", systolic_finish, 1);
        check("d_acc_coincident", accumulator_done, 1);
        @(negedge clk);
        check("d_direct_out", out_valid, 1);
        check("d_core_en_off", core_en, 0);
        observe();
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            @(negedge clk);
            observe();
        end
        check("d_done_seen", done, 1);
        check("d_beats", beats, 40);
        pulse_start();
        flag = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (busy || core_rst) flag = 1'b1;
            @(negedge clk);
        end
        check("d_start_in_done_ignored", flag, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
